// File: rtl/fetch_stage_pkg.sv
// Shared constants and state encoding for the instruction fetch stage.
package fetch_stage_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  localparam logic [15:0] DEF_RESET_PC = 16'h0000;
  localparam logic [15:0] DEF_PC_INC   = 16'h0002;
  localparam logic [3:0]  DEF_HALT_OP  = 4'hF;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch stage bus: pipeline control in, instruction memory port, IF/ID register out.
interface fetch_stage_if;

  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic [15:0] ifid_pc;
  logic [15:0] ifid_pc_next;
  logic [15:0] ifid_instr;
  logic        ifid_valid;
  logic        halted;

  // Fetch stage side: drives the memory address and the IF/ID register.
  modport master (
    input  stall, flush, branch_taken, branch_target, imem_data,
    output imem_addr, ifid_pc, ifid_pc_next, ifid_instr, ifid_valid, halted
  );

  // Surrounding pipeline / memory side.
  modport slave (
    output stall, flush, branch_taken, branch_target, imem_data,
    input  imem_addr, ifid_pc, ifid_pc_next, ifid_instr, ifid_valid, halted
  );

endinterface

// File: rtl/fetch_stage_adder.sv
// 16-bit combinational adder; result wraps modulo 2^16, carry discarded.
module fetch_stage_adder (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] y
);

  assign y = a + b;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and RUN/HALT FSM.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [15:0] RESET_PC = DEF_RESET_PC,
  parameter logic [15:0] PC_INC   = DEF_PC_INC,
  parameter logic [3:0]  HALT_OP  = DEF_HALT_OP
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
);

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d, pc_inc;
  logic [15:0] ifid_pc_q, ifid_pc_d;
  logic [15:0] ifid_pc_next_q, ifid_pc_next_d;
  logic [15:0] ifid_instr_q, ifid_instr_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [15:0] redirect_pc;

  fetch_stage_adder u_pc_add (
    .a(pc_q),
    .b(PC_INC),
    .y(pc_inc)
  );

  // Branch targets are forced halfword-aligned.
  assign redirect_pc = bus.branch_target & 16'hFFFE;

  assign bus.imem_addr    = pc_q;
  assign bus.ifid_pc      = ifid_pc_q;
  assign bus.ifid_pc_next = ifid_pc_next_q;
  assign bus.ifid_instr   = ifid_instr_q;
  assign bus.ifid_valid   = ifid_valid_q;
  assign bus.halted       = (state_q == HALT);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // Next state and next PC / IF/ID values; priority branch > stall > flush > normal.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    ifid_pc_d      = ifid_pc_q;
    ifid_pc_next_d = ifid_pc_next_q;
    ifid_instr_d   = ifid_instr_q;
    ifid_valid_d   = ifid_valid_q;
    unique case (state_q)
      RUN: begin
        if (bus.branch_taken) begin
          pc_d         = redirect_pc;
          ifid_valid_d = 1'b0;
        end else if (bus.stall) begin
          // hold everything
        end else if (bus.flush) begin
          pc_d         = pc_inc;
          ifid_valid_d = 1'b0;
        end else begin
          ifid_pc_d      = pc_q;
          ifid_pc_next_d = pc_inc;
          ifid_instr_d   = bus.imem_data;
          ifid_valid_d   = 1'b1;
          // A latched halt word parks the PC on itself.
          if (bus.imem_data[15:12] == HALT_OP) state_d = HALT;
          else                                 pc_d    = pc_inc;
        end
      end
      HALT: begin
        ifid_valid_d = 1'b0;
        if (bus.branch_taken) begin
          pc_d    = redirect_pc;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // PC and IF/ID pipeline register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q           <= RESET_PC;
      ifid_pc_q      <= '0;
      ifid_pc_next_q <= '0;
      ifid_instr_q   <= '0;
      ifid_valid_q   <= 1'b0;
    end else begin
      pc_q           <= pc_d;
      ifid_pc_q      <= ifid_pc_d;
      ifid_pc_next_q <= ifid_pc_next_d;
      ifid_instr_q   <= ifid_instr_d;
      ifid_valid_q   <= ifid_valid_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage with hand-computed expected values.
module tb_fetch_stage;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  fetch_stage_if bus ();

  fetch_stage #(
    .RESET_PC(16'h0000),
    .PC_INC  (16'h0002),
    .HALT_OP (4'hF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input logic [15:0] a);
    bus.stall = 1'b0; bus.flush = 1'b0;
    bus.branch_taken = 1'b1; bus.branch_target = a;
    step();
    bus.branch_taken = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    checks++; if (bus.imem_addr !== 16'h0000) begin errors++; $display("FAIL reset_addr got %h exp %h", bus.imem_addr, 16'h0000); end
    checks++; if (bus.ifid_pc !== 16'h0000) begin errors++; $display("FAIL reset_ifid_pc got %h exp %h", bus.ifid_pc, 16'h0000); end
    checks++; if (bus.ifid_pc_next !== 16'h0000) begin errors++; $display("FAIL reset_pc_next got %h exp %h", bus.ifid_pc_next, 16'h0000); end
    checks++; if (bus.ifid_instr !== 16'h0000) begin errors++; $display("FAIL reset_instr got %h exp %h", bus.ifid_instr, 16'h0000); end
    checks++; if (bus.ifid_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.ifid_valid); end
    checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b exp 0", bus.halted); end
  endtask

  task automatic test_first_fetch();
    rst = 1'b0; bus.imem_data = 16'h1234;
    step();
    checks++; if (bus.ifid_pc !== 16'h0000) begin errors++; $display("FAIL first_pc got %h exp %h", bus.ifid_pc, 16'h0000); end
    checks++; if (bus.ifid_pc_next !== 16'h0002) begin errors++; $display("FAIL first_pc_next got %h exp %h", bus.ifid_pc_next, 16'h0002); end
    checks++; if (bus.ifid_instr !== 16'h1234) begin errors++; $display("FAIL first_instr got %h exp %h", bus.ifid_instr, 16'h1234); end
    checks++; if (bus.ifid_valid !== 1'b1) begin errors++; $display("FAIL first_valid got %b exp 1", bus.ifid_valid); end
    checks++; if (bus.imem_addr !== 16'h0002) begin errors++; $display("FAIL first_addr got %h exp %h", bus.imem_addr, 16'h0002); end
  endtask

  task automatic test_stall();
    goto(16'h000E);
    bus.imem_data = 16'h1111;
    step();
    bus.stall = 1'b1; bus.imem_data = 16'h9999;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (bus.imem_addr !== 16'h0010) begin errors++; $display("FAIL stall_addr[%0d] got %h exp %h", i, bus.imem_addr, 16'h0010); end
      checks++; if (bus.ifid_pc !== 16'h000E) begin errors++; $display("FAIL stall_ifid_pc[%0d] got %h exp %h", i, bus.ifid_pc, 16'h000E); end
      checks++; if (bus.ifid_instr !== 16'h1111) begin errors++; $display("FAIL stall_instr[%0d] got %h exp %h", i, bus.ifid_instr, 16'h1111); end
      checks++; if (bus.ifid_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got %b exp 1", i, bus.ifid_valid); end
    end
    bus.stall = 1'b0; bus.imem_data = 16'h2222;
    step();
    checks++; if (bus.ifid_pc !== 16'h0010) begin errors++; $display("FAIL unstall_ifid_pc got %h exp %h", bus.ifid_pc, 16'h0010); end
    checks++; if (bus.ifid_instr !== 16'h2222) begin errors++; $display("FAIL unstall_instr got %h exp %h", bus.ifid_instr, 16'h2222); end
    checks++; if (bus.imem_addr !== 16'h0012) begin errors++; $display("FAIL unstall_addr got %h exp %h", bus.imem_addr, 16'h0012); end
  endtask

  task automatic test_branch_over_stall();
    bus.branch_taken = 1'b1; bus.stall = 1'b1; bus.branch_target = 16'h00A5;
    step();
    checks++; if (bus.imem_addr !== 16'h00A4) begin errors++; $display("FAIL br_addr got %h exp %h", bus.imem_addr, 16'h00A4); end
    checks++; if (bus.ifid_valid !== 1'b0) begin errors++; $display("FAIL br_valid got %b exp 0", bus.ifid_valid); end
    bus.branch_taken = 1'b0; bus.stall = 1'b0; bus.imem_data = 16'h3333;
    step();
    checks++; if (bus.ifid_pc !== 16'h00A4) begin errors++; $display("FAIL br_ifid_pc got %h exp %h", bus.ifid_pc, 16'h00A4); end
    checks++; if (bus.ifid_pc_next !== 16'h00A6) begin errors++; $display("FAIL br_pc_next got %h exp %h", bus.ifid_pc_next, 16'h00A6); end
    checks++; if (bus.ifid_valid !== 1'b1) begin errors++; $display("FAIL br_valid2 got %b exp 1", bus.ifid_valid); end
  endtask

  task automatic test_wrap();
    goto(16'hFFFE);
    bus.imem_data = 16'h4444;
    step();
    checks++; if (bus.ifid_pc !== 16'hFFFE) begin errors++; $display("FAIL wrap_ifid_pc got %h exp %h", bus.ifid_pc, 16'hFFFE); end
    checks++; if (bus.ifid_pc_next !== 16'h0000) begin errors++; $display("FAIL wrap_pc_next got %h exp %h", bus.ifid_pc_next, 16'h0000); end
    checks++; if (bus.imem_addr !== 16'h0000) begin errors++; $display("FAIL wrap_addr got %h exp %h", bus.imem_addr, 16'h0000); end
  endtask

  task automatic test_flush();
    goto(16'h0030);
    bus.flush = 1'b1; bus.imem_data = 16'h5555;
    step();
    checks++; if (bus.imem_addr !== 16'h0032) begin errors++; $display("FAIL flush_addr got %h exp %h", bus.imem_addr, 16'h0032); end
    checks++; if (bus.ifid_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b exp 0", bus.ifid_valid); end
    bus.flush = 1'b0; bus.imem_data = 16'h6666;
    step();
    checks++; if (bus.ifid_pc !== 16'h0032) begin errors++; $display("FAIL postflush_pc got %h exp %h", bus.ifid_pc, 16'h0032); end
    checks++; if (bus.ifid_instr !== 16'h6666) begin errors++; $display("FAIL postflush_instr got %h exp %h", bus.ifid_instr, 16'h6666); end
    checks++; if (bus.ifid_valid !== 1'b1) begin errors++; $display("FAIL postflush_valid got %b exp 1", bus.ifid_valid); end
  endtask

  task automatic test_stall_and_flush();
    bus.stall = 1'b1; bus.flush = 1'b1; bus.imem_data = 16'h7070;
    step();
    checks++; if (bus.imem_addr !== 16'h0034) begin errors++; $display("FAIL sf_addr got %h exp %h", bus.imem_addr, 16'h0034); end
    checks++; if (bus.ifid_valid !== 1'b1) begin errors++; $display("FAIL sf_valid got %b exp 1", bus.ifid_valid); end
    checks++; if (bus.ifid_pc !== 16'h0032) begin errors++; $display("FAIL sf_ifid_pc got %h exp %h", bus.ifid_pc, 16'h0032); end
    bus.stall = 1'b0; bus.flush = 1'b0;
  endtask

  task automatic test_halt();
    goto(16'h0020);
    bus.imem_data = 16'hF000;
    step();
    checks++; if (bus.halted !== 1'b1) begin errors++; $display("FAIL halt_enter got %b exp 1", bus.halted); end
    checks++; if (bus.ifid_valid !== 1'b1) begin errors++; $display("FAIL halt_word_valid got %b exp 1", bus.ifid_valid); end
    checks++; if (bus.ifid_instr !== 16'hF000) begin errors++; $display("FAIL halt_word got %h exp %h", bus.ifid_instr, 16'hF000); end
    checks++; if (bus.imem_addr !== 16'h0020) begin errors++; $display("FAIL halt_addr got %h exp %h", bus.imem_addr, 16'h0020); end
    bus.stall = 1'b1; bus.flush = 1'b1;
    step();
    checks++; if (bus.halted !== 1'b1) begin errors++; $display("FAIL halt_hold got %b exp 1", bus.halted); end
    checks++; if (bus.ifid_valid !== 1'b0) begin errors++; $display("FAIL halt_bubble got %b exp 0", bus.ifid_valid); end
    checks++; if (bus.imem_addr !== 16'h0020) begin errors++; $display("FAIL halt_addr2 got %h exp %h", bus.imem_addr, 16'h0020); end
    bus.stall = 1'b0; bus.flush = 1'b0;
    bus.branch_taken = 1'b1; bus.branch_target = 16'h0040;
    step();
    checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL halt_exit got %b exp 0", bus.halted); end
    checks++; if (bus.imem_addr !== 16'h0040) begin errors++; $display("FAIL halt_exit_addr got %h exp %h", bus.imem_addr, 16'h0040); end
    bus.branch_taken = 1'b0; bus.imem_data = 16'h0001;
    step();
    checks++; if (bus.ifid_pc !== 16'h0040) begin errors++; $display("FAIL resume_pc got %h exp %h", bus.ifid_pc, 16'h0040); end
    checks++; if (bus.ifid_valid !== 1'b1) begin errors++; $display("FAIL resume_valid got %b exp 1", bus.ifid_valid); end
  endtask

  task automatic test_halt_vs_branch();
    bus.imem_data = 16'hF000; bus.branch_taken = 1'b1; bus.branch_target = 16'h0050;
    step();
    checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL hb_halted got %b exp 0", bus.halted); end
    checks++; if (bus.imem_addr !== 16'h0050) begin errors++; $display("FAIL hb_addr got %h exp %h", bus.imem_addr, 16'h0050); end
    checks++; if (bus.ifid_valid !== 1'b0) begin errors++; $display("FAIL hb_valid got %b exp 0", bus.ifid_valid); end
    bus.branch_taken = 1'b0;
    step();
    checks++; if (bus.halted !== 1'b1) begin errors++; $display("FAIL hb_halt2 got %b exp 1", bus.halted); end
    checks++; if (bus.imem_addr !== 16'h0050) begin errors++; $display("FAIL hb_addr2 got %h exp %h", bus.imem_addr, 16'h0050); end
  endtask

  task automatic test_reset_override();
    rst = 1'b1; bus.branch_taken = 1'b1; bus.branch_target = 16'h0080; bus.stall = 1'b1;
    step();
    checks++; if (bus.imem_addr !== 16'h0000) begin errors++; $display("FAIL rov_addr got %h exp %h", bus.imem_addr, 16'h0000); end
    checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL rov_halted got %b exp 0", bus.halted); end
    checks++; if (bus.ifid_pc !== 16'h0000) begin errors++; $display("FAIL rov_ifid_pc got %h exp %h", bus.ifid_pc, 16'h0000); end
    checks++; if (bus.ifid_instr !== 16'h0000) begin errors++; $display("FAIL rov_instr got %h exp %h", bus.ifid_instr, 16'h0000); end
    checks++; if (bus.ifid_valid !== 1'b0) begin errors++; $display("FAIL rov_valid got %b exp 0", bus.ifid_valid); end
    rst = 1'b0; bus.branch_taken = 1'b0; bus.stall = 1'b0; bus.imem_data = 16'h7777;
    step();
    checks++; if (bus.ifid_pc !== 16'h0000) begin errors++; $display("FAIL rov_first_pc got %h exp %h", bus.ifid_pc, 16'h0000); end
    checks++; if (bus.ifid_instr !== 16'h7777) begin errors++; $display("FAIL rov_first_instr got %h exp %h", bus.ifid_instr, 16'h7777); end
    checks++; if (bus.ifid_valid !== 1'b1) begin errors++; $display("FAIL rov_first_valid got %b exp 1", bus.ifid_valid); end
    checks++; if (bus.imem_addr !== 16'h0002) begin errors++; $display("FAIL rov_first_addr got %h exp %h", bus.imem_addr, 16'h0002); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_target = '0;
    bus.imem_data = '0;
    test_reset();
    test_first_fetch();
    test_stall();
    test_branch_over_stall();
    test_wrap();
    test_flush();
    test_stall_and_flush();
    test_halt();
    test_halt_vs_branch();
    test_reset_override();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
